// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: FSM state codes, redirect sources and word geometry.
// Redirect source codes are ordered so that a numerically larger code wins.
package mips_pkg;

  localparam int WORD       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_e;

  function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
    return {addr[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select among exception, jump and taken-branch redirects.
// Produces the word-aligned target and flags a misaligned raw jump/branch target.
module pc_redirect_mux
  import mips_pkg::*;
#(
  parameter logic [WORD-1:0] EXC_VECTOR = 32'h80000180
) (
  input  logic            exc_i,
  input  logic            jump_i,
  input  logic [WORD-1:0] jump_target_i,
  input  logic            br_taken_i,
  input  logic [WORD-1:0] br_target_i,
  output redir_src_e      src_o,
  output logic [WORD-1:0] target_o,
  output logic            misalign_o
);

  always_comb begin
    src_o      = SRC_NONE;
    target_o   = '0;
    misalign_o = 1'b0;
    if (exc_i) begin
      src_o    = SRC_EXC;
      target_o = word_align(EXC_VECTOR);
    end else if (jump_i) begin
      src_o      = SRC_JMP;
      target_o   = word_align(jump_target_i);
      misalign_o = |jump_target_i[1:0];
    end else if (br_taken_i) begin
      src_o      = SRC_BR;
      target_o   = word_align(br_target_i);
      misalign_o = |br_target_i[1:0];
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer: HOLD after reset, then ISSUE/WAIT single-outstanding fetch loop.
// Redirects in WAIT are parked in a pending register and squash the returning fetch.
module pc_fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [WORD-1:0] EXC_VECTOR   = 32'h80000180,
  parameter int unsigned     HOLD_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            R,
  input  logic            stall,
  input  logic            exc,
  input  logic            jump,
  input  logic [WORD-1:0] jump_target,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  output logic [WORD-1:0] pc_out,
  output logic [WORD-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            addr_err
);

  localparam int unsigned        HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WORD-1:0]    STEP      = WORD'(INSN_BYTES);

  logic [1:0]        state_q, state_d;
  logic [WORD-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic              fv_q, fv_d;
  logic              aerr_q, aerr_d;
  logic              squash_q, squash_d;
  redir_src_e        pend_src_q, pend_src_d;
  logic [WORD-1:0]   pend_tgt_q, pend_tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  redir_src_e        redir_src;
  logic [WORD-1:0]   redir_tgt;
  logic              redir_mis;
  logic              redir_valid;

  pc_redirect_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_mux (
    .exc_i         (exc),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .src_o         (redir_src),
    .target_o      (redir_tgt),
    .misalign_o    (redir_mis)
  );

  assign redir_valid = (redir_src != SRC_NONE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    fv_d       = 1'b0;
    aerr_d     = 1'b0;
    squash_d   = squash_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    hold_d     = hold_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_ISSUE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_ISSUE: begin
        if (redir_valid) begin
          pc_d   = redir_tgt;
          aerr_d = redir_mis;
        end
        if (!stall) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          state_d    = ST_ISSUE;
          req_d      = 1'b0;
          fv_d       = !(squash_q || redir_valid);
          squash_d   = 1'b0;
          pend_src_d = SRC_NONE;
          if (redir_valid) begin
            pc_d   = redir_tgt;
            aerr_d = redir_mis;
          end else if (pend_src_q != SRC_NONE) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = pc_q + STEP;
          end
        // SRC_NONE is the lowest code, so an empty pending slot is always overwritten
        end else if (redir_valid && (redir_src >= pend_src_q)) begin
          pend_src_d = redir_src;
          pend_tgt_d = redir_tgt;
          squash_d   = 1'b1;
          aerr_d     = redir_mis;
        end
      end
      default: begin
        state_d = ST_HOLD;
        req_d   = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q    <= ST_HOLD;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      fv_q       <= 1'b0;
      aerr_q     <= 1'b0;
      squash_q   <= 1'b0;
      pend_src_q <= SRC_NONE;
      pend_tgt_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      fv_q       <= fv_d;
      aerr_q     <= aerr_d;
      squash_q   <= squash_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
      hold_q     <= hold_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + STEP;
  assign fetch_valid = fv_q;
  assign addr_err    = aerr_q;

endmodule
